// File: rtl/id_stage_pipe_if.sv
// ID/EX pipeline-register bundle between the decode stage (master) and EX (slave).
interface id_stage_pipe_if #(
  parameter int DATA_W = 32
);
  logic              ex_valid;
  logic [31:0]       ex_pc;
  logic [31:0]       ex_instr;
  logic [DATA_W-1:0] ex_rs_data;
  logic [DATA_W-1:0] ex_rt_data;
  logic [DATA_W-1:0] ex_imm;
  logic [DATA_W-1:0] ex_link;

  modport master (
    output ex_valid, ex_pc, ex_instr, ex_rs_data, ex_rt_data, ex_imm, ex_link
  );

  modport slave (
    input ex_valid, ex_pc, ex_instr, ex_rs_data, ex_rt_data, ex_imm, ex_link
  );
endinterface

// File: rtl/id_stage_pipe.sv
// MIPS decode stage: GRF with write-through bypass, operand forwarding, early branch/jump
// resolution and the ID/EX register. Optional macro GRF_TRACE_EN adds wb_pc_i and a write trace.
module id_stage_pipe #(
  parameter int DATA_W     = 32,
  parameter int NUM_FWD    = 3,
  parameter int DELAY_SLOT = 1,
  parameter int SEL_W      = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      stall_i,
  input  logic                      flush_i,
  input  logic                      if_valid_i,
  input  logic [31:0]               if_pc_i,
  input  logic [31:0]               if_instr_i,
  input  logic                      wb_we_i,
  input  logic [4:0]                wb_wa_i,
  input  logic [DATA_W-1:0]         wb_wd_i,
`ifdef GRF_TRACE_EN
  input  logic [31:0]               wb_pc_i,
`endif
  input  logic [SEL_W-1:0]          fwd_sel_rs_i,
  input  logic [SEL_W-1:0]          fwd_sel_rt_i,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_data_i,
  output logic [31:0]               npc_o,
  output logic                      branch_taken_o,
  id_stage_pipe_if.master           ex_o
);

  // Selects beyond NUM_FWD fall through to the GRF/bypass value.
  function automatic logic [DATA_W-1:0] fwd_mux(
    input logic [SEL_W-1:0]          sel,
    input logic [DATA_W-1:0]         grf_val,
    input logic [NUM_FWD*DATA_W-1:0] buses
  );
    fwd_mux = grf_val;
    for (int k = 1; k <= NUM_FWD; k++) begin
      if (sel == SEL_W'(k)) begin
        fwd_mux = buses[k*DATA_W-1 -: DATA_W];
      end
    end
  endfunction

  logic [DATA_W-1:0] grf_q [32];

  logic [5:0]  op;
  logic [4:0]  rs_a, rt_a;
  logic [5:0]  funct;
  logic [15:0] imm16;
  logic [31:0] pc4, br_tgt, j_tgt, link32;
  logic [DATA_W-1:0] rs_grf, rt_grf, rs_fwd, rt_fwd, imm_ext, link_ext;
  logic rs_neg, rs_zero, rs_eq_rt;
  logic take, is_link, go;
  logic [31:0] tgt;

  assign op    = if_instr_i[31:26];
  assign rs_a  = if_instr_i[25:21];
  assign rt_a  = if_instr_i[20:16];
  assign imm16 = if_instr_i[15:0];
  assign funct = if_instr_i[5:0];

  assign pc4    = if_pc_i + 32'd4;
  assign br_tgt = pc4 + {{14{imm16[15]}}, imm16, 2'b00};
  assign j_tgt  = {pc4[31:28], if_instr_i[25:0], 2'b00};
  assign link32 = if_pc_i + ((DELAY_SLOT != 0) ? 32'd8 : 32'd4);

  assign rs_grf = (rs_a == 5'd0) ? {DATA_W{1'b0}} :
                  (wb_we_i && (wb_wa_i == rs_a)) ? wb_wd_i : grf_q[rs_a];
  assign rt_grf = (rt_a == 5'd0) ? {DATA_W{1'b0}} :
                  (wb_we_i && (wb_wa_i == rt_a)) ? wb_wd_i : grf_q[rt_a];

  assign rs_fwd   = fwd_mux(fwd_sel_rs_i, rs_grf, fwd_data_i);
  assign rt_fwd   = fwd_mux(fwd_sel_rt_i, rt_grf, fwd_data_i);
  assign rs_neg   = rs_fwd[DATA_W-1];
  assign rs_zero  = (rs_fwd == {DATA_W{1'b0}});
  assign rs_eq_rt = (rs_fwd == rt_fwd);
  assign go       = if_valid_i && !stall_i && !flush_i;

  // Branch/jump condition and target decode.
  always_comb begin
    take    = 1'b0;
    tgt     = 32'd0;
    is_link = 1'b0;
    case (op)
      6'h01: begin
        tgt = br_tgt;
        case (rt_a)
          5'h00:   take = rs_neg;
          5'h01:   take = !rs_neg;
          default: take = 1'b0;
        endcase
      end
      6'h02: begin
        take = 1'b1;
        tgt  = j_tgt;
      end
      6'h03: begin
        take    = 1'b1;
        tgt     = j_tgt;
        is_link = 1'b1;
      end
      6'h04: begin take = rs_eq_rt;            tgt = br_tgt; end
      6'h05: begin take = !rs_eq_rt;           tgt = br_tgt; end
      6'h06: begin take = rs_neg || rs_zero;   tgt = br_tgt; end
      6'h07: begin take = !rs_neg && !rs_zero; tgt = br_tgt; end
      6'h00: begin
        if (funct == 6'h08) begin
          take = 1'b1;
          tgt  = rs_fwd[31:0];
        end else if (funct == 6'h09) begin
          take    = 1'b1;
          tgt     = rs_fwd[31:0];
          is_link = 1'b1;
        end else begin
          take = 1'b0;
        end
      end
      default: take = 1'b0;
    endcase
  end

  assign branch_taken_o = go && take;
  assign npc_o          = (go && take) ? tgt : 32'd0;
  assign link_ext       = is_link ? DATA_W'(link32) : {DATA_W{1'b0}};

  // Immediate extension: logical ops zero-extend, lui shifts, everything else sign-extends.
  always_comb begin
    case (op)
      6'h0C, 6'h0D, 6'h0E: imm_ext = DATA_W'(imm16);
      6'h0F:               imm_ext = DATA_W'({imm16, 16'h0000});
      default:             imm_ext = DATA_W'($signed(imm16));
    endcase
  end

  // GRF: $0 is never written; reset clears every entry.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) begin
        grf_q[i] <= {DATA_W{1'b0}};
      end
    end else if (wb_we_i && (wb_wa_i != 5'd0)) begin
      grf_q[wb_wa_i] <= wb_wd_i;
`ifdef GRF_TRACE_EN
      $display("@%h: $%d <= %h", wb_pc_i, wb_wa_i, wb_wd_i);
`endif
    end
  end

  logic              ex_valid_q;
  logic [31:0]       ex_pc_q, ex_instr_q;
  logic [DATA_W-1:0] ex_rs_q, ex_rt_q, ex_imm_q, ex_link_q;

  // ID/EX register: reset, flush, stall and an empty slot all produce an all-zero bubble.
  always_ff @(posedge clk) begin
    if (!reset_n || flush_i || stall_i || !if_valid_i) begin
      ex_valid_q <= 1'b0;
      ex_pc_q    <= 32'd0;
      ex_instr_q <= 32'd0;
      ex_rs_q    <= {DATA_W{1'b0}};
      ex_rt_q    <= {DATA_W{1'b0}};
      ex_imm_q   <= {DATA_W{1'b0}};
      ex_link_q  <= {DATA_W{1'b0}};
    end else begin
      ex_valid_q <= 1'b1;
      ex_pc_q    <= if_pc_i;
      ex_instr_q <= if_instr_i;
      ex_rs_q    <= rs_fwd;
      ex_rt_q    <= rt_fwd;
      ex_imm_q   <= imm_ext;
      ex_link_q  <= link_ext;
    end
  end

  assign ex_o.ex_valid   = ex_valid_q;
  assign ex_o.ex_pc      = ex_pc_q;
  assign ex_o.ex_instr   = ex_instr_q;
  assign ex_o.ex_rs_data = ex_rs_q;
  assign ex_o.ex_rt_data = ex_rt_q;
  assign ex_o.ex_imm     = ex_imm_q;
  assign ex_o.ex_link    = ex_link_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Scoreboard bench for id_stage_pipe: the driver queues expected branch and ID/EX results,
// a negedge monitor pops and compares them.
module tb_id_stage_pipe;

  logic        clk;
  logic        reset_n;
  logic        stall_i, flush_i, if_valid_i;
  logic [31:0] if_pc_i, if_instr_i;
  logic        wb_we_i;
  logic [4:0]  wb_wa_i;
  logic [31:0] wb_wd_i;
  logic [31:0] wb_pc_i;
  logic [1:0]  fwd_sel_rs_i, fwd_sel_rt_i;
  logic [95:0] fwd_data_i;
  logic [31:0] npc_o;
  logic        branch_taken_o;

  id_stage_pipe_if #(.DATA_W(32)) ex_if ();

  id_stage_pipe #(.DATA_W(32), .NUM_FWD(3), .DELAY_SLOT(1), .SEL_W(2)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .stall_i        (stall_i),
    .flush_i        (flush_i),
    .if_valid_i     (if_valid_i),
    .if_pc_i        (if_pc_i),
    .if_instr_i     (if_instr_i),
    .wb_we_i        (wb_we_i),
    .wb_wa_i        (wb_wa_i),
    .wb_wd_i        (wb_wd_i),
`ifdef GRF_TRACE_EN
    .wb_pc_i        (wb_pc_i),
`endif
    .fwd_sel_rs_i   (fwd_sel_rs_i),
    .fwd_sel_rt_i   (fwd_sel_rt_i),
    .fwd_data_i     (fwd_data_i),
    .npc_o          (npc_o),
    .branch_taken_o (branch_taken_o),
    .ex_o           (ex_if)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] imm;
    logic [31:0] link;
  } ex_t;

  typedef struct packed {
    logic        taken;
    logic [31:0] npc;
  } br_t;

  ex_t ex_q[$];
  br_t br_q[$];
  int  vectors = 0;
  int  miscompares = 0;
  logic mon_en = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] funct);
    return {6'h00, rs, rt, rd, 5'd0, funct};
  endfunction

  function automatic logic [31:0] jtype(input logic [5:0] op, input logic [25:0] idx);
    return {op, idx};
  endfunction

  task automatic issue(
    input logic rst, input logic v, input logic [31:0] pc, input logic [31:0] instr,
    input logic st, input logic fl,
    input logic we, input logic [4:0] wa, input logic [31:0] wd,
    input logic [1:0] srs, input logic [1:0] srt, input logic [95:0] fwd,
    input logic etk, input logic [31:0] enpc,
    input logic [31:0] ers, input logic [31:0] ert, input logic [31:0] eimm,
    input logic [31:0] elink
  );
    ex_t e;
    br_t b;
    @(posedge clk);
    #1;
    reset_n      = rst;
    if_valid_i   = v;
    if_pc_i      = pc;
    if_instr_i   = instr;
    stall_i      = st;
    flush_i      = fl;
    wb_we_i      = we;
    wb_wa_i      = wa;
    wb_wd_i      = wd;
    wb_pc_i      = pc;
    fwd_sel_rs_i = srs;
    fwd_sel_rt_i = srt;
    fwd_data_i   = fwd;
    b.taken = etk;
    b.npc   = enpc;
    br_q.push_back(b);
    if (rst && v && !st && !fl) begin
      e.pc = pc; e.instr = instr; e.rs = ers; e.rt = ert; e.imm = eimm; e.link = elink;
      ex_q.push_back(e);
    end
  endtask

  task automatic idle();
    issue(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 2'd0, 2'd0, 96'd0,
          1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
  endtask

  // Monitor: branch outputs for the current drive, ID/EX contents from the previous one.
  always @(negedge clk) begin
    br_t b;
    ex_t e;
    ex_t got;
    if (mon_en) begin
      if (br_q.size() > 0) begin
        b = br_q.pop_front();
        vectors++;
        if ({branch_taken_o, npc_o} !== b) begin
          miscompares++;
          $display("FAIL branch: got taken=%b npc=%h, expected taken=%b npc=%h",
                   branch_taken_o, npc_o, b.taken, b.npc);
        end
      end
      got = {ex_if.ex_pc, ex_if.ex_instr, ex_if.ex_rs_data, ex_if.ex_rt_data,
             ex_if.ex_imm, ex_if.ex_link};
      vectors++;
      if (ex_if.ex_valid === 1'b1) begin
        if (ex_q.size() == 0) begin
          miscompares++;
          $display("FAIL idex_unexpected: got valid=1 %h, expected bubble", got);
        end else begin
          e = ex_q.pop_front();
          if (got !== e) begin
            miscompares++;
            $display("FAIL idex_fields: got %h, expected %h", got, e);
          end
        end
      end else if ((ex_if.ex_valid !== 1'b0) || (got !== '0)) begin
        miscompares++;
        $display("FAIL idex_bubble: got valid=%b %h, expected all zero",
                 ex_if.ex_valid, got);
      end
    end
  end

  initial begin
    reset_n = 1'b0; stall_i = 1'b0; flush_i = 1'b0; if_valid_i = 1'b0;
    if_pc_i = 32'd0; if_instr_i = 32'd0; wb_we_i = 1'b0; wb_wa_i = 5'd0;
    wb_wd_i = 32'd0; wb_pc_i = 32'd0; fwd_sel_rs_i = 2'd0; fwd_sel_rt_i = 2'd0;
    fwd_data_i = 96'd0;
    @(posedge clk);
    #1 mon_en = 1'b1;

    // Reset held, then GRF reads after reset.
    issue(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 2'd0, 2'd0, 96'd0,
          1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    issue(1'b1, 1'b1, 32'h100, rtype(5'd1, 5'd2, 5'd3, 6'h21), 1'b0, 1'b0,
          1'b0, 5'd0, 32'd0, 2'd0, 2'd0, 96'd0,
          1'b0, 32'd0, 32'd0, 32'd0, 32'h1821, 32'd0);
    // Write-through bypass, then the same value from the GRF.
    issue(1'b1, 1'b1, 32'h104, rtype(5'd5, 5'd0, 5'd3, 6'h21), 1'b0, 1'b0,
          1'b1, 5'd5, 32'h1234, 2'd0, 2'd0, 96'd0,
          1'b0, 32'd0, 32'h1234, 32'd0, 32'h1821, 32'd0);
    issue(1'b1, 1'b1, 32'h108, rtype(5'd5, 5'd5, 5'd3, 6'h21), 1'b0, 1'b0,
          1'b1, 5'd2, 32'd7, 2'd0, 2'd0, 96'd0,
          1'b0, 32'd0, 32'h1234, 32'h1234, 32'h1821, 32'd0);
    // beq with rs forwarded from slice 1.
    issue(1'b1, 1'b1, 32'h3000, itype(6'h04, 5'd1, 5'd2, 16'hFFFF), 1'b0, 1'b0,
          1'b0, 5'd0, 32'd0, 2'd2, 2'd0, {32'd0, 32'd7, 32'd0},
          1'b1, 32'h3000, 32'd7, 32'd7, 32'hFFFFFFFF, 32'd0);
    // bne taken, then stalled, stall+flush, flush.
    issue(1'b1, 1'b1, 32'h4000, itype(6'h05, 5'd1, 5'd2, 16'h0010), 1'b0, 1'b0,
          1'b0, 5'd0, 32'd0, 2'd0, 2'd0, 96'd0,
          1'b1, 32'h4044, 32'd0, 32'd7, 32'h10, 32'd0);
    issue(1'b1, 1'b1, 32'h4000, itype(6'h05, 5'd1, 5'd2, 16'h0010), 1'b1, 1'b0,
          1'b0, 5'd0, 32'd0, 2'd0, 2'd0, 96'd0,
          1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    issue(1'b1, 1'b1, 32'h4000, itype(6'h05, 5'd1, 5'd2, 16'h0010), 1'b1, 1'b1,
          1'b0, 5'd0, 32'd0, 2'd0, 2'd0, 96'd0,
          1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    issue(1'b1, 1'b1, 32'h4000, itype(6'h05, 5'd1, 5'd2, 16'h0010), 1'b0, 1'b1,
          1'b0, 5'd0, 32'd0, 2'd0, 2'd0, 96'd0,
          1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    // jal with link = pc+8.
    issue(1'b1, 1'b1, 32'h3004, jtype(6'h03, 26'h0000C00), 1'b0, 1'b0,
          1'b0, 5'd0, 32'd0, 2'd0, 2'd0, 96'd0,
          1'b1, 32'h3000, 32'd0, 32'd0, 32'h0C00, 32'h300C);
    // $0 write is ignored, both by bypass and GRF.
    issue(1'b1, 1'b1, 32'h110, rtype(5'd0, 5'd0, 5'd3, 6'h21), 1'b0, 1'b0,
          1'b1, 5'd0, 32'hFFFF, 2'd0, 2'd0, 96'd0,
          1'b0, 32'd0, 32'd0, 32'd0, 32'h1821, 32'd0);
    issue(1'b1, 1'b1, 32'h114, rtype(5'd0, 5'd5, 5'd3, 6'h21), 1'b0, 1'b0,
          1'b0, 5'd0, 32'd0, 2'd0, 2'd0, 96'd0,
          1'b0, 32'd0, 32'd0, 32'h1234, 32'h1821, 32'd0);
    // REGIMM bltz / bgez on a forwarded negative value.
    issue(1'b1, 1'b1, 32'h5000, itype(6'h01, 5'd7, 5'd0, 16'h0002), 1'b0, 1'b0,
          1'b0, 5'd0, 32'd0, 2'd3, 2'd0, {32'h80000000, 32'd0, 32'd0},
          1'b1, 32'h500C, 32'h80000000, 32'd0, 32'd2, 32'd0);
    issue(1'b1, 1'b1, 32'h5004, itype(6'h01, 5'd7, 5'd1, 16'h0002), 1'b0, 1'b0,
          1'b0, 5'd0, 32'd0, 2'd3, 2'd0, {32'h80000000, 32'd0, 32'd0},
          1'b0, 32'd0, 32'h80000000, 32'd0, 32'd2, 32'd0);
    // blez / bgtz boundaries around zero.
    issue(1'b1, 1'b1, 32'h6000, itype(6'h06, 5'd1, 5'd0, 16'h0001), 1'b0, 1'b0,
          1'b0, 5'd0, 32'd0, 2'd0, 2'd0, 96'd0,
          1'b1, 32'h6008, 32'd0, 32'd0, 32'd1, 32'd0);
    issue(1'b1, 1'b1, 32'h7000, itype(6'h07, 5'd5, 5'd0, 16'hFFFE), 1'b0, 1'b0,
          1'b0, 5'd0, 32'd0, 2'd0, 2'd0, 96'd0,
          1'b1, 32'h6FFC, 32'h1234, 32'd0, 32'hFFFFFFFE, 32'd0);
    issue(1'b1, 1'b1, 32'h7100, itype(6'h07, 5'd1, 5'd0, 16'h0004), 1'b0, 1'b0,
          1'b0, 5'd0, 32'd0, 2'd0, 2'd0, 96'd0,
          1'b0, 32'd0, 32'd0, 32'd0, 32'd4, 32'd0);
    // jr / jalr.
    issue(1'b1, 1'b1, 32'h8000, rtype(5'd5, 5'd0, 5'd0, 6'h08), 1'b0, 1'b0,
          1'b0, 5'd0, 32'd0, 2'd0, 2'd0, 96'd0,
          1'b1, 32'h1234, 32'h1234, 32'd0, 32'h8, 32'd0);
    issue(1'b1, 1'b1, 32'h8000, rtype(5'd5, 5'd0, 5'd31, 6'h09), 1'b0, 1'b0,
          1'b0, 5'd0, 32'd0, 2'd0, 2'd0, 96'd0,
          1'b1, 32'h1234, 32'h1234, 32'd0, 32'hFFFFF809, 32'h8008);
    // Immediate extension variants.
    issue(1'b1, 1'b1, 32'h9000, itype(6'h0C, 5'd0, 5'd0, 16'h8000), 1'b0, 1'b0,
          1'b0, 5'd0, 32'd0, 2'd0, 2'd0, 96'd0,
          1'b0, 32'd0, 32'd0, 32'd0, 32'h00008000, 32'd0);
    issue(1'b1, 1'b1, 32'h9004, itype(6'h0F, 5'd0, 5'd0, 16'h8001), 1'b0, 1'b0,
          1'b0, 5'd0, 32'd0, 2'd0, 2'd0, 96'd0,
          1'b0, 32'd0, 32'd0, 32'd0, 32'h80010000, 32'd0);
    issue(1'b1, 1'b1, 32'h9008, itype(6'h09, 5'd0, 5'd0, 16'h8000), 1'b0, 1'b0,
          1'b0, 5'd0, 32'd0, 2'd0, 2'd0, 96'd0,
          1'b0, 32'd0, 32'd0, 32'd0, 32'hFFFF8000, 32'd0);
    // Invalid slot never resolves.
    issue(1'b1, 1'b0, 32'hA000, itype(6'h04, 5'd0, 5'd0, 16'h0004), 1'b0, 1'b0,
          1'b0, 5'd0, 32'd0, 2'd0, 2'd0, 96'd0,
          1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    // Reset mid-operation: branch still follows inputs, GRF and ID/EX are cleared.
    issue(1'b0, 1'b1, 32'hA000, itype(6'h04, 5'd0, 5'd0, 16'h0004), 1'b0, 1'b0,
          1'b0, 5'd0, 32'd0, 2'd0, 2'd0, 96'd0,
          1'b1, 32'hA014, 32'd0, 32'd0, 32'd0, 32'd0);
    issue(1'b1, 1'b1, 32'hB000, rtype(5'd5, 5'd2, 5'd3, 6'h21), 1'b0, 1'b0,
          1'b0, 5'd0, 32'd0, 2'd0, 2'd0, 96'd0,
          1'b0, 32'd0, 32'd0, 32'd0, 32'h1821, 32'd0);
    issue(1'b1, 1'b1, 32'hB004, rtype(5'd5, 5'd2, 5'd3, 6'h21), 1'b0, 1'b0,
          1'b0, 5'd0, 32'd0, 2'd0, 2'd1, {32'd0, 32'd0, 32'hDEADBEEF},
          1'b0, 32'd0, 32'd0, 32'hDEADBEEF, 32'h1821, 32'd0);

    repeat (3) idle();
    @(negedge clk);
    #1;
    vectors++;
    if (ex_q.size() != 0) begin
      miscompares++;
      $display("FAIL idex_drain: got %0d results still pending, expected 0", ex_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
